// File: rtl/shift_reg_seq.sv
// Parametrised load/shift register with a counted multi-step shift sequencer.
// Supports logical, rotate, arithmetic and serial-in fill modes with busy/done status.
module shift_reg_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_in,
  input  logic             ld,
  input  logic             start,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             ser_in,
  input  logic [CNT_W-1:0] amount,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t             state_r, state_s;
  logic [WIDTH-1:0]   q_r, q_s;
  logic               ser_r, ser_s;
  logic               done_r, done_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               dir_r, dir_s;
  logic [1:0]         mode_r, mode_s;
  logic               out_bit_s;
  logic               fill_s;
  logic               busy_s;

  // Arithmetic fill only sign-extends on right shifts; left shifts bring in zero.
  function automatic logic fill_bit(
    input logic [1:0] m,
    input logic       d,
    input logic       out_bit,
    input logic       msb,
    input logic       si
  );
    logic f;
    case (m)
      2'b00:   f = 1'b0;
      2'b01:   f = out_bit;
      2'b10:   f = d ? 1'b0 : msb;
      2'b11:   f = si;
      default: f = 1'b0;
    endcase
    return f;
  endfunction

  // State and datapath registers; rst aborts any sequence without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      q_r     <= {WIDTH{1'b0}};
      ser_r   <= 1'b0;
      done_r  <= 1'b0;
      cnt_r   <= CNT_ZERO;
      dir_r   <= 1'b0;
      mode_r  <= 2'b00;
    end else begin
      state_r <= state_s;
      q_r     <= q_s;
      ser_r   <= ser_s;
      done_r  <= done_s;
      cnt_r   <= cnt_s;
      dir_r   <= dir_s;
      mode_r  <= mode_s;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_s   = state_r;
    q_s       = q_r;
    ser_s     = ser_r;
    done_s    = 1'b0;
    cnt_s     = cnt_r;
    dir_s     = dir_r;
    mode_s    = mode_r;
    out_bit_s = 1'b0;
    fill_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ld) begin
          q_s = d_in;
        end else if (start) begin
          dir_s  = dir;
          mode_s = mode;
          cnt_s  = amount;
          if (amount != CNT_ZERO) begin
            state_s = ST_SHIFT;
          end else begin
            done_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        out_bit_s = dir_r ? q_r[WIDTH-1] : q_r[0];
        fill_s    = fill_bit(mode_r, dir_r, out_bit_s, q_r[WIDTH-1], ser_in);
        if (dir_r) begin
          q_s = {q_r[WIDTH-2:0], fill_s};
        end else begin
          q_s = {fill_s, q_r[WIDTH-1:1]};
        end
        ser_s = out_bit_s;
        cnt_s = cnt_r - CNT_ONE;
        // The step that consumes the last count also returns to idle.
        if (cnt_r == CNT_ONE) begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Status decode from the state register.
  always_comb begin
    busy_s = 1'b0;
    if (state_r == ST_SHIFT) begin
      busy_s = 1'b1;
    end else begin
      busy_s = 1'b0;
    end
  end

  assign q       = q_r;
  assign ser_out = ser_r;
  assign busy    = busy_s;
  assign done    = done_r;

endmodule

// File: tb/tb_shift_reg_seq.sv
// Self-checking bench for shift_reg_seq: table-driven per-cycle vectors with a
// scoreboard queue, plus a hand-written max-amount rotate sequence.
module tb_shift_reg_seq;

  logic       clk;
  logic       rst;
  logic [7:0] d_in;
  logic       ld;
  logic       start;
  logic       dir;
  logic [1:0] mode;
  logic       ser_in;
  logic [3:0] amount;
  logic [7:0] q;
  logic       ser_out;
  logic       busy;
  logic       done;

  typedef struct {
    logic       rst;
    logic       ld;
    logic       start;
    logic       dir;
    logic [1:0] mode;
    logic       ser_in;
    logic [3:0] amount;
    logic [7:0] d_in;
    logic [7:0] exp_q;
    logic       exp_busy;
    logic       exp_done;
    logic       exp_ser;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic       busy;
    logic       done;
    logic       ser;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec;
  int   n_bad;

  shift_reg_seq #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .ld(ld), .start(start), .dir(dir),
    .mode(mode), .ser_in(ser_in), .amount(amount), .q(q), .ser_out(ser_out),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic l, input logic s, input logic dr,
                     input logic [1:0] m, input logic si, input logic [3:0] a,
                     input logic [7:0] di, input logic [7:0] eq, input logic eb,
                     input logic ed, input logic es);
    vec_t v;
    v.rst = r; v.ld = l; v.start = s; v.dir = dr; v.mode = m; v.ser_in = si;
    v.amount = a; v.d_in = di; v.exp_q = eq; v.exp_busy = eb; v.exp_done = ed;
    v.exp_ser = es;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    exp_t got;
    rst = v.rst; ld = v.ld; start = v.start; dir = v.dir; mode = v.mode;
    ser_in = v.ser_in; amount = v.amount; d_in = v.d_in;
    e.q = v.exp_q; e.busy = v.exp_busy; e.done = v.exp_done; e.ser = v.exp_ser;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    n_vec++;
    if (q !== got.q || busy !== got.busy || done !== got.done || ser_out !== got.ser) begin
      n_bad++;
      $display("FAIL vec%0d: got q=%h busy=%b done=%b ser=%b, want q=%h busy=%b done=%b ser=%b",
               idx, q, busy, done, ser_out, got.q, got.busy, got.done, got.ser);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; ld = 1'b0; start = 1'b0; dir = 1'b0; mode = 2'b00;
    ser_in = 1'b0; amount = 4'd0; d_in = 8'h00;
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    int cyc;
    n_vec = 0;
    n_bad = 0;
    idle_inputs();
    rst = 1'b1;

    //   rst  ld    st    dir   mode   si    amt    d_in   q      busy  done  ser
    add(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4'd0, 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'd0, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0);
    // rotate right by 3
    add(1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 4'd3, 8'h00, 8'hA5, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 4'd0, 8'h00, 8'hD2, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'd0, 8'h00, 8'h69, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'd0, 8'h00, 8'hB4, 1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'd0, 8'h00, 8'hB4, 1'b0, 1'b0, 1'b1);
    // arithmetic right by 2
    add(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4'd0, 8'h90, 8'h90, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 4'd2, 8'h00, 8'h90, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'd0, 8'h00, 8'hC8, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'd0, 8'h00, 8'hE4, 1'b0, 1'b1, 1'b0);
    // logical left by 4
    add(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4'd0, 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 4'd4, 8'h00, 8'hA5, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'd0, 8'h00, 8'h4A, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'd0, 8'h00, 8'h94, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'd0, 8'h00, 8'h28, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'd0, 8'h00, 8'h50, 1'b0, 1'b1, 1'b0);
    // serial-in fill left by 8, ld/start while busy must be ignored
    add(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 1'b1, 4'd8, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 4'd0, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 4'd2, 8'h3C, 8'h03, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 4'd2, 8'h3C, 8'h07, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 4'd0, 8'h00, 8'h0F, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 4'd0, 8'h00, 8'h1F, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 4'd0, 8'h00, 8'h3F, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 4'd0, 8'h00, 8'h7F, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 4'd0, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0);
    // amount 0 accepted in the done cycle, then amount 1 in that done cycle
    add(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 4'd0, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 4'd1, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'd0, 8'h00, 8'h7F, 1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'd0, 8'h00, 8'h7F, 1'b0, 1'b0, 1'b1);
    // reset mid-sequence aborts without done
    add(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4'd0, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 4'd5, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'd0, 8'h00, 8'h7F, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'd0, 8'h00, 8'h3F, 1'b1, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4'd0, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
    end

    // Max amount rotate-left by 15 on 8 bits equals rotate-left by 7.
    idle_inputs();
    ld = 1'b1; d_in = 8'h81;
    @(posedge clk); #1;
    idle_inputs();
    start = 1'b1; dir = 1'b1; mode = 2'b01; amount = 4'd15;
    @(posedge clk); #1;
    idle_inputs();
    busy_cnt = 0;
    done_cnt = 0;
    cyc = 0;
    while (done_cnt == 0 && cyc < 40) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      if (done) done_cnt++;
      cyc++;
    end
    check("max_amt_done_seen", done_cnt, 1);
    check("max_amt_busy_cycles", busy_cnt, 15);
    check("max_amt_q", {24'd0, q}, 32'h000000C0);
    check("max_amt_ser_out", {31'd0, ser_out}, 32'd0);
    @(posedge clk); #1;
    check("max_amt_done_one_cycle", {31'd0, done}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
